// File: rtl/hazard_ctrl.sv
// Pipeline hazard/stall controller for the RV32I 5-stage core: load-use, EX redirect, dmem wait.
// Optional macro HAZARD_PERF_CNT_EN builds the stall/redirect performance counters.
module hazard_ctrl #(
   parameter int MEM_TIMEOUT = 16,
   parameter int CNT_W       = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [4:0]       rs1_D,
   input  logic [4:0]       rs2_D,
   input  logic             rs1_used_D,
   input  logic             rs2_used_D,
   input  logic [4:0]       rd_E,
   input  logic             mem_read_E,
   input  logic             redirect_E,
   input  logic             dmem_req_M,
   input  logic             dmem_ack_M,
   output logic             bubbleF,
   output logic             bubbleD,
   output logic             bubbleE,
   output logic             bubbleM,
   output logic             bubbleW,
   output logic             flushD,
   output logic             flushE,
   output logic             flushM,
   output logic             flushW,
   output logic             mem_timeout,
   output logic [CNT_W-1:0] stall_cycles,
   output logic [CNT_W-1:0] redirect_cnt
);

   localparam int WCNT_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      WAIT = 1'b1
   } state_t;

   state_t            state_r;
   logic [WCNT_W-1:0] wcnt_r;
   logic              wcnt_max_s;
   logic              mstall_s;
   logic              timeout_s;
   logic              lu_s;

   assign wcnt_max_s = (wcnt_r == WCNT_W'(MEM_TIMEOUT - 1));

   // Memory stall and forced-release detection for the current state
   always_comb begin
      mstall_s  = 1'b0;
      timeout_s = 1'b0;
      case (state_r)
         IDLE: begin
            mstall_s  = dmem_req_M & ~dmem_ack_M;
            timeout_s = 1'b0;
         end
         WAIT: begin
            mstall_s  = ~dmem_ack_M & ~wcnt_max_s;
            // An ack arriving on the last count wins over the timeout
            timeout_s = ~dmem_ack_M & wcnt_max_s;
         end
         default: begin
            mstall_s  = 1'b0;
            timeout_s = 1'b0;
         end
      endcase
   end

   assign lu_s = mem_read_E & (rd_E != 5'd0) &
                 ((rs1_used_D & (rs1_D == rd_E)) | (rs2_used_D & (rs2_D == rd_E)));

   // Prioritised stage hold/clear controls; zero latency from inputs and state
   always_comb begin
      bubbleF     = 1'b0;
      bubbleD     = 1'b0;
      bubbleE     = 1'b0;
      bubbleM     = 1'b0;
      bubbleW     = 1'b0;
      flushD      = 1'b0;
      flushE      = 1'b0;
      flushM      = 1'b0;
      flushW      = 1'b0;
      mem_timeout = 1'b0;
      if (rst) begin
         flushD = 1'b1;
         flushE = 1'b1;
         flushM = 1'b1;
         flushW = 1'b1;
      end else if (mstall_s) begin
         bubbleF = 1'b1;
         bubbleD = 1'b1;
         bubbleE = 1'b1;
         bubbleM = 1'b1;
         flushW  = 1'b1;
      end else if (redirect_E) begin
         flushD      = 1'b1;
         flushE      = 1'b1;
         mem_timeout = timeout_s;
      end else if (lu_s) begin
         bubbleF     = 1'b1;
         bubbleD     = 1'b1;
         flushE      = 1'b1;
         mem_timeout = timeout_s;
      end else begin
         mem_timeout = timeout_s;
      end
   end

   // Memory-wait state machine with timeout counter
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= IDLE;
         wcnt_r  <= {WCNT_W{1'b0}};
      end else begin
         case (state_r)
            IDLE: begin
               if (mstall_s) begin
                  state_r <= WAIT;
                  wcnt_r  <= WCNT_W'(1);
               end else begin
                  state_r <= IDLE;
                  wcnt_r  <= {WCNT_W{1'b0}};
               end
            end
            WAIT: begin
               if (dmem_ack_M | wcnt_max_s) begin
                  state_r <= IDLE;
                  wcnt_r  <= {WCNT_W{1'b0}};
               end else begin
                  state_r <= WAIT;
                  wcnt_r  <= wcnt_r + WCNT_W'(1);
               end
            end
            default: begin
               state_r <= IDLE;
               wcnt_r  <= {WCNT_W{1'b0}};
            end
         endcase
      end
   end

`ifdef HAZARD_PERF_CNT_EN
   logic [CNT_W-1:0] stall_cnt_r;
   logic [CNT_W-1:0] redir_cnt_r;
   logic             redirect_apply_s;

   assign redirect_apply_s = redirect_E & ~mstall_s;

   // Performance counters, wrapping modulo 2^CNT_W
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cnt_r <= {CNT_W{1'b0}};
         redir_cnt_r <= {CNT_W{1'b0}};
      end else begin
         if (bubbleD) begin
            stall_cnt_r <= stall_cnt_r + CNT_W'(1);
         end else begin
            stall_cnt_r <= stall_cnt_r;
         end
         if (redirect_apply_s) begin
            redir_cnt_r <= redir_cnt_r + CNT_W'(1);
         end else begin
            redir_cnt_r <= redir_cnt_r;
         end
      end
   end

   assign stall_cycles = stall_cnt_r;
   assign redirect_cnt = redir_cnt_r;
`else
   assign stall_cycles = {CNT_W{1'b0}};
   assign redirect_cnt = {CNT_W{1'b0}};
`endif

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard and stall controller for the RV32I 5-stage core. Generates the per-stage `bubbleX` (hold) and `flushX` (clear) controls consumed by the IF/ID/EX/MEM/WB pipeline registers. It resolves load-use hazards, EX-stage branch/jump redirects and multi-cycle data-memory waits, and tracks memory-wait timeouts. Pipeline registers apply `bubbleX` with priority over `flushX`: hold if bubble, else clear if flush, else load.

## Interface
- `MEM_TIMEOUT`, 16: max cycles spent in WAIT before forced release; must be ≥ 2.
- `CNT_W`, 32: width of the performance counters.

- `clk` in 1: core clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `rs1_D`, `rs2_D` in 5 each: source registers of the instruction in ID.
- `rs1_used_D`, `rs2_used_D` in 1 each: the corresponding source is actually read.
- `rd_E` in 5: destination of the instruction in EX.
- `mem_read_E` in 1: instruction in EX is a load.
- `redirect_E` in 1: branch taken or jump resolved in EX.
- `dmem_req_M` in 1: MEM stage has an outstanding data-memory access.
- `dmem_ack_M` in 1: data memory completes the access this cycle.
- `bubbleF`, `bubbleD`, `bubbleE`, `bubbleM`, `bubbleW` out 1: hold the stage register.
- `flushD`, `flushE`, `flushM`, `flushW` out 1: clear the stage register.
- `mem_timeout` out 1: one-cycle pulse when a WAIT is force-released.
- `stall_cycles` out CNT_W: count of cycles with `bubbleD`=1.
- `redirect_cnt` out CNT_W: count of cycles in which a redirect flush is applied.

## Operation
- State machine `IDLE`/`WAIT` plus a wait counter `wcnt`, which is $clog2(MEM_TIMEOUT) bits wide. Control outputs are combinational from the inputs and the state.
- **Memory stall** (`mstall`):
  - In IDLE: `mstall = dmem_req_M & ~dmem_ack_M`.
  - In WAIT: `mstall = ~dmem_ack_M & ~(wcnt == MEM_TIMEOUT-1)`.
- **Transitions:**
  - IDLE→WAIT when `mstall`; `wcnt` is set to 1.
  - In WAIT, `wcnt` increments each cycle.
  - WAIT→IDLE on `dmem_ack_M`, or when `wcnt == MEM_TIMEOUT-1`. In the timeout case `mem_timeout`=1 for that cycle.
  - A timeout while `dmem_ack_M`=1 counts as an ack and produces no pulse.
- **Load-use hazard:** `lu = mem_read_E & rd_E != 0 & ((rs1_used_D & rs1_D == rd_E) | (rs2_used_D & rs2_D == rd_E))`.
- **Priority, highest first:**
  1. `mstall`: `bubbleF`..`bubbleM`=1, `flushW`=1, all other flushes 0. Redirect and load-use are deferred; their inputs stay stable because EX is held.
  2. `redirect_E`: `flushD`=`flushE`=1, all bubbles 0. Load-use is suppressed because the ID instruction is discarded.
  3. `lu`: `bubbleF`=`bubbleD`=1, `flushE`=1.
  4. Otherwise all outputs are 0.
- **Reset:**
  - While `rst`=1: all bubbles 0; `flushD`/`E`/`M`/`W`=1; `mem_timeout`=0.
  - State goes to IDLE, `wcnt`=0, counters=0, all asynchronously.

## Timing
- Stall response is zero-latency: the same cycle as `dmem_req_M` without ack, or as `lu`/`redirect_E`.
- Load-use costs exactly 1 bubble cycle. On the next cycle the load is in MEM, so `lu`=0.
- A redirect costs 2 squashed instructions, with `flushD`/`flushE` asserted for exactly one cycle.
- A memory wait of N cycles (ack in the N+1th request cycle) gives N stall cycles. It is capped at MEM_TIMEOUT-1 stall cycles.
- Back-to-back requests: IDLE→WAIT is allowed in the cycle right after WAIT→IDLE.
- If `rst` is asserted mid-WAIT, the controller returns to IDLE immediately and stalls are released.
- Counters wrap modulo 2^CNT_W.

## Configuration
- `HAZARD_PERF_CNT_EN` defined: `stall_cycles` increments on each non-reset cycle with `bubbleD`=1. `redirect_cnt` increments on each cycle where priority case 2 applies.
- `HAZARD_PERF_CNT_EN` undefined: counter registers are not built; both ports are tied to 0. The ports remain present.

## Test plan
- Load `x5` in EX (`mem_read_E`=1, `rd_E`=5), `rs1_D`=5, `rs1_used_D`=1 → one cycle of `bubbleF`=`bubbleD`=`flushE`=1, then all 0. With the macro, `stall_cycles`=1.
- Same as above with `rd_E`=0, or with `rs1_used_D`=0 → no bubble or flush.
- `redirect_E`=1 together with the load-use condition → `flushD`=`flushE`=1, `bubbleF`=`bubbleD`=0. With the macro, `redirect_cnt`=1.
- `dmem_req_M`=1, ack after 3 cycles → `bubbleF`..`bubbleM`=1 and `flushW`=1 for 3 cycles, released on the ack cycle. `mem_timeout` never asserts.
- MEM_TIMEOUT=4, `dmem_req_M` held with no ack → 3 stall cycles. `mem_timeout` pulses in the 4th cycle with stalls released, then a new WAIT starts the following cycle.
- `rst` pulsed during WAIT → outputs immediately go to the reset values. After release, state is IDLE and counters read 0.
